id_ex_stage: RTL and testbench

- ID/EX pipeline register of the 5-stage bypassing core.
- Sits between the decode stage (register file read plus the ALU-op controller) and the ALU.
- Latches the decoded ALU_OP, operands and control bits, and applies EX/MEM and MEM/WB forwarding to the latched operands.
- Handles stall-hold, flush-to-bubble and load-use hazard detection.

---
 rtl/id_ex_stage.sv | 126 ++++++++++++
 tb/tb_id_ex_stage.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: latches decoded fields and forwards EX/MEM and MEM/WB results onto the operands.
// Optional ID_EX_PERF_CNT_EN adds bubble and stall counters.
module id_ex_stage #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall,
    input  logic              flush,
    input  logic              in_valid,
    input  logic [XLEN-1:0]   in_pc,
    input  logic [3:0]        in_alu_op,
    input  logic [XLEN-1:0]   in_rs1_data,
    input  logic [XLEN-1:0]   in_rs2_data,
    input  logic [XLEN-1:0]   in_imm,
    input  logic [REG_AW-1:0] in_rs1,
    input  logic [REG_AW-1:0] in_rs2,
    input  logic [REG_AW-1:0] in_rd,
    input  logic              in_alu_src,
    input  logic              in_reg_write,
    input  logic              in_mem_read,
    input  logic              in_mem_write,
    input  logic [REG_AW-1:0] exmem_rd,
    input  logic              exmem_reg_write,
    input  logic [XLEN-1:0]   exmem_result,
    input  logic [REG_AW-1:0] memwb_rd,
    input  logic              memwb_reg_write,
    input  logic [XLEN-1:0]   memwb_data,
    output logic              ex_valid,
    output logic [XLEN-1:0]   ex_pc,
    output logic [3:0]        ex_alu_op,
    output logic [XLEN-1:0]   ex_a,
    output logic [XLEN-1:0]   ex_b,
    output logic [XLEN-1:0]   ex_store_data,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              ex_mem_write,
    output logic              load_use_hazard
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       perf_bubbles,
    output logic [31:0]       perf_stalls
`endif
);

    logic [XLEN-1:0]   rs1_data_q, rs2_data_q, imm_q;
    logic [REG_AW-1:0] rs1_q, rs2_q;
    logic              alu_src_q;
    logic              wb_hit_rs1, wb_hit_rs2;
    logic              ex_hit_rs1, ex_hit_rs2;
    logic [XLEN-1:0]   fwd_rs1, fwd_rs2;

    assign wb_hit_rs1 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs1_q);
    assign wb_hit_rs2 = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == rs2_q);
    assign ex_hit_rs1 = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs1_q);
    assign ex_hit_rs2 = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == rs2_q);

    // Reset and flush both produce an all-zero bubble.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_alu_op    <= '0;
            rs1_data_q   <= '0;
            rs2_data_q   <= '0;
            imm_q        <= '0;
            rs1_q        <= '0;
            rs2_q        <= '0;
            ex_rd        <= '0;
            alu_src_q    <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_mem_read  <= 1'b0;
            ex_mem_write <= 1'b0;
        end else if (stall) begin
            // A write retiring while we hold must land in the held operand.
            if (wb_hit_rs1) rs1_data_q <= memwb_data;
            if (wb_hit_rs2) rs2_data_q <= memwb_data;
        end else begin
            ex_valid     <= in_valid;
            ex_pc        <= in_pc;
            ex_alu_op    <= in_alu_op;
            rs1_data_q   <= in_rs1_data;
            rs2_data_q   <= in_rs2_data;
            imm_q        <= in_imm;
            rs1_q        <= in_rs1;
            rs2_q        <= in_rs2;
            ex_rd        <= in_rd;
            alu_src_q    <= in_alu_src;
            ex_reg_write <= in_valid & in_reg_write;
            ex_mem_read  <= in_valid & in_mem_read;
            ex_mem_write <= in_valid & in_mem_write;
        end
    end

    always_comb begin
        fwd_rs1 = rs1_data_q;
        if (ex_hit_rs1)      fwd_rs1 = exmem_result;
        else if (wb_hit_rs1) fwd_rs1 = memwb_data;
        fwd_rs2 = rs2_data_q;
        if (ex_hit_rs2)      fwd_rs2 = exmem_result;
        else if (wb_hit_rs2) fwd_rs2 = memwb_data;
    end

    assign ex_a          = fwd_rs1;
    assign ex_b          = alu_src_q ? imm_q : fwd_rs2;
    assign ex_store_data = fwd_rs2;

    assign load_use_hazard = ex_valid && ex_mem_read && (ex_rd != '0) && in_valid &&
                             ((ex_rd == in_rs1) || (ex_rd == in_rs2));

`ifdef ID_EX_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_bubbles <= '0;
            perf_stalls  <= '0;
        end else if (flush) begin
            perf_bubbles <= perf_bubbles + 32'd1;
        end else if (stall) begin
            perf_stalls  <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed scenarios plus random traffic against a behavioural model.
// Perf counter checks compile only with ID_EX_PERF_CNT_EN.
module tb_id_ex_stage;

    logic        clk = 1'b0;
    logic        rst, stall, flush, in_valid;
    logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
    logic [3:0]  in_alu_op;
    logic [4:0]  in_rs1, in_rs2, in_rd;
    logic        in_alu_src, in_reg_write, in_mem_read, in_mem_write;
    logic [4:0]  exmem_rd, memwb_rd;
    logic        exmem_reg_write, memwb_reg_write;
    logic [31:0] exmem_result, memwb_data;
    logic        ex_valid;
    logic [31:0] ex_pc, ex_a, ex_b, ex_store_data;
    logic [3:0]  ex_alu_op;
    logic [4:0]  ex_rd;
    logic        ex_reg_write, ex_mem_read, ex_mem_write, load_use_hazard;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] perf_bubbles, perf_stalls;
`endif

    id_ex_stage dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .in_valid(in_valid), .in_pc(in_pc), .in_alu_op(in_alu_op),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
        .in_alu_src(in_alu_src), .in_reg_write(in_reg_write),
        .in_mem_read(in_mem_read), .in_mem_write(in_mem_write),
        .exmem_rd(exmem_rd), .exmem_reg_write(exmem_reg_write), .exmem_result(exmem_result),
        .memwb_rd(memwb_rd), .memwb_reg_write(memwb_reg_write), .memwb_data(memwb_data),
        .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_alu_op(ex_alu_op),
        .ex_a(ex_a), .ex_b(ex_b), .ex_store_data(ex_store_data), .ex_rd(ex_rd),
        .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .load_use_hazard(load_use_hazard)
`ifdef ID_EX_PERF_CNT_EN
        , .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls)
`endif
    );

    always #5 clk = ~clk;

    int  n_checks = 0;
    int  n_fails  = 0;
    bit  chk_en   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: the instruction currently held in EX
    typedef struct {
        bit        valid;
        bit [31:0] pc, r1d, r2d, imm;
        bit [3:0]  op;
        bit [4:0]  rs1, rs2, rd;
        bit        src, rw, mr, mw;
    } instr_t;

    instr_t m;
    bit [31:0] m_bub, m_stl;

    always @(posedge clk) begin
        if (rst) begin
            m = '{default: 0};
            m_bub = 0;
            m_stl = 0;
        end else if (flush) begin
            m = '{default: 0};
            m_bub++;
        end else if (stall) begin
            m_stl++;
            if (memwb_reg_write && memwb_rd != 0 && memwb_rd == m.rs1) m.r1d = memwb_data;
            if (memwb_reg_write && memwb_rd != 0 && memwb_rd == m.rs2) m.r2d = memwb_data;
        end else begin
            m.valid = in_valid;   m.pc  = in_pc;      m.op  = in_alu_op;
            m.r1d   = in_rs1_data; m.r2d = in_rs2_data; m.imm = in_imm;
            m.rs1   = in_rs1;     m.rs2 = in_rs2;     m.rd  = in_rd;
            m.src   = in_alu_src;
            m.rw    = in_valid && in_reg_write;
            m.mr    = in_valid && in_mem_read;
            m.mw    = in_valid && in_mem_write;
        end
    end

    function automatic logic [31:0] fwd(input logic [4:0] idx, input logic [31:0] d);
        if (idx == 0) return d;
        if (exmem_reg_write && exmem_rd == idx) return exmem_result;
        if (memwb_reg_write && memwb_rd == idx) return memwb_data;
        return d;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic hz;
            hz = m.valid && m.mr && m.rd != 0 && in_valid && (m.rd == in_rs1 || m.rd == in_rs2);
            chk("m_valid", {31'b0, ex_valid}, {31'b0, m.valid});
            chk("m_pc", ex_pc, m.pc);
            chk("m_alu_op", {28'b0, ex_alu_op}, {28'b0, m.op});
            chk("m_rd", {27'b0, ex_rd}, {27'b0, m.rd});
            chk("m_ctrl", {29'b0, ex_reg_write, ex_mem_read, ex_mem_write}, {29'b0, m.rw, m.mr, m.mw});
            chk("m_store", ex_store_data, fwd(m.rs2, m.r2d));
            chk("m_hazard", {31'b0, load_use_hazard}, {31'b0, hz});
            if (m.valid) begin
                chk("m_a", ex_a, fwd(m.rs1, m.r1d));
                chk("m_b", ex_b, m.src ? m.imm : fwd(m.rs2, m.r2d));
            end
`ifdef ID_EX_PERF_CNT_EN
            chk("m_perf_bub", perf_bubbles, m_bub);
            chk("m_perf_stl", perf_stalls, m_stl);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; flush = 0; in_valid = 0; in_pc = 0; in_alu_op = 0;
        in_rs1_data = 0; in_rs2_data = 0; in_imm = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0;
        in_alu_src = 0; in_reg_write = 0; in_mem_read = 0; in_mem_write = 0;
        exmem_rd = 0; exmem_reg_write = 0; exmem_result = 0;
        memwb_rd = 0; memwb_reg_write = 0; memwb_data = 0;
    endtask

    initial begin
        rst = 1;
        idle_inputs();
        // Reset, then an ADD op=5 rd=3 waiting on the inputs
        in_valid = 1; in_alu_op = 4'd5; in_rd = 5'd3; in_reg_write = 1; in_pc = 32'h100;
        tick();
        chk_en = 1;
        tick();
        @(negedge clk);
        chk("rst_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_alu_op", {28'b0, ex_alu_op}, 32'd0);
        chk("rst_rd", {27'b0, ex_rd}, 32'd0);
        chk("rst_reg_write", {31'b0, ex_reg_write}, 32'd0);
        rst = 0;
        tick();
        @(negedge clk);
        chk("add_valid", {31'b0, ex_valid}, 32'd1);
        chk("add_alu_op", {28'b0, ex_alu_op}, 32'd5);
        chk("add_rd", {27'b0, ex_rd}, 32'd3);

        // Forwarding priority on rs1
        in_rs1 = 5'd4; in_rs1_data = 32'h10;
        tick();
        exmem_rd = 5'd4; exmem_reg_write = 1; exmem_result = 32'h55;
        memwb_rd = 5'd4; memwb_reg_write = 1; memwb_data = 32'h66;
        @(negedge clk);
        chk("fwd_exmem", ex_a, 32'h55);
        #1 exmem_reg_write = 0;
        @(negedge clk);
        chk("fwd_memwb", ex_a, 32'h66);
        #1 exmem_reg_write = 1; exmem_rd = 5'd0; memwb_reg_write = 0;
        @(negedge clk);
        chk("fwd_rd0", ex_a, 32'h10);

        // ADDI: immediate on B, forwarded rs2 on store data
        #1 idle_inputs();
        in_valid = 1; in_alu_src = 1; in_imm = 32'hFFFFFFFC; in_rs2 = 5'd6; in_rs2_data = 32'h1;
        tick();
        exmem_rd = 5'd6; exmem_reg_write = 1; exmem_result = 32'h77;
        @(negedge clk);
        chk("addi_b", ex_b, 32'hFFFFFFFC);
        chk("addi_store", ex_store_data, 32'h77);

        // lw x5 followed by a consumer of x5
        #1 idle_inputs();
        in_valid = 1; in_mem_read = 1; in_reg_write = 1; in_rd = 5'd5; in_alu_op = 4'd2;
        tick();
        in_mem_read = 0; in_rd = 5'd8; in_rs1 = 5'd5;
        @(negedge clk);
        chk("lu_hazard", {31'b0, load_use_hazard}, 32'd1);
        #1 stall = 1; flush = 1;
        tick();
        @(negedge clk);
        chk("lu_bubble_valid", {31'b0, ex_valid}, 32'd0);
        chk("lu_bubble_rw", {31'b0, ex_reg_write}, 32'd0);
        chk("lu_bubble_op", {28'b0, ex_alu_op}, 32'd0);
        chk("lu_bubble_hz", {31'b0, load_use_hazard}, 32'd0);

        // Stall while MEM/WB retires x7 into the held rs2
        #1 idle_inputs();
        in_valid = 1; in_alu_op = 4'd3; in_rd = 5'd9; in_rs1 = 5'd2; in_rs1_data = 32'h22;
        in_rs2 = 5'd7; in_rs2_data = 32'h1; in_mem_write = 1;
        tick();
        stall = 1; memwb_rd = 5'd7; memwb_reg_write = 1; memwb_data = 32'hABCD;
        in_rs2_data = 32'hDEAD; in_rd = 5'd1; in_alu_op = 4'd9;
        tick(); tick(); tick();
        memwb_reg_write = 0;
        @(negedge clk);
        chk("hold_store", ex_store_data, 32'hABCD);
        chk("hold_rd", {27'b0, ex_rd}, 32'd9);
        chk("hold_op", {28'b0, ex_alu_op}, 32'd3);
        chk("hold_a", ex_a, 32'h22);
        chk("hold_mw", {31'b0, ex_mem_write}, 32'd1);

`ifdef ID_EX_PERF_CNT_EN
        #1 idle_inputs();
        rst = 1;
        tick();
        rst = 0;
        @(negedge clk);
        chk("perf_rst_bub", perf_bubbles, 32'd0);
        chk("perf_rst_stl", perf_stalls, 32'd0);
        #1 stall = 1;
        tick(); tick(); tick();
        stall = 0; flush = 1;
        tick(); tick();
        stall = 1;
        tick();
        stall = 0; flush = 0;
        @(negedge clk);
        chk("perf_stalls", perf_stalls, 32'd3);
        chk("perf_bubbles", perf_bubbles, 32'd3);
`endif

        // Random traffic against the model
        #1;
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 49) == 0);
            flush = ($urandom_range(0, 7) == 0);
            stall = ($urandom_range(0, 3) == 0);
            in_valid = ($urandom_range(0, 4) != 0);
            in_pc = $urandom; in_alu_op = 4'($urandom);
            in_rs1_data = $urandom; in_rs2_data = $urandom; in_imm = $urandom;
            in_rs1 = 5'($urandom_range(0, 7)); in_rs2 = 5'($urandom_range(0, 7));
            in_rd  = 5'($urandom_range(0, 7));
            in_alu_src = 1'($urandom); in_reg_write = 1'($urandom);
            in_mem_read = 1'($urandom); in_mem_write = 1'($urandom);
            exmem_rd = 5'($urandom_range(0, 7)); exmem_reg_write = 1'($urandom);
            exmem_result = $urandom;
            memwb_rd = 5'($urandom_range(0, 7)); memwb_reg_write = 1'($urandom);
            memwb_data = $urandom;
            tick();
        end
        @(negedge clk);
        #1 chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
